// File: rtl/width_expander_if.sv
// Valid/ready stream bundle: the producer drives valid and data, the consumer drives ready.
interface width_expander_if #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/width_expander.sv
// Packs a stream of narrow {last, elem} beats into wide words of up to NO lanes
// plus an active-lane count, presented on a registered valid/ready producer.
module width_expander #(
    parameter int W_DATA   = 16,
    parameter int NO       = 4,
    parameter int W_ACTIVE = 3
) (
    input  logic                clk,
    input  logic                rst,
    width_expander_if.slave     din,
    width_expander_if.master    dout
);
    localparam int CNT_W = $clog2(NO);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W_ACTIVE-1:0] active_q, active_d;
    logic [W_DATA-1:0]   data_q [NO];
    logic [W_DATA-1:0]   data_d [NO];

    logic                din_ready_s;
    logic                din_hs_s;
    logic                dout_hs_s;
    logic                elem_last_s;
    logic [W_DATA-1:0]   elem_s;
    logic [NO*W_DATA-1:0] lanes_s;

    assign elem_last_s = din.data[W_DATA];
    assign elem_s      = din.data[W_DATA-1:0];

    // While holding a word the next element may only enter as the word leaves.
    assign din_ready_s = (state_q == FILL) ? 1'b1 : dout.ready;
    assign din_hs_s    = din.valid & din_ready_s;
    assign dout_hs_s   = (state_q == HOLD) & dout.ready;
    assign din.ready   = din_ready_s;

    // Flatten the lane buffer into the output word, lane 0 in the LSBs.
    always_comb begin
        lanes_s = '0;
        for (int i = 0; i < NO; i++) begin
            lanes_s[i*W_DATA +: W_DATA] = data_q[i];
        end
    end

    assign dout.valid = (state_q == HOLD);
    assign dout.data  = {active_q, lanes_s};

    // Next-state, lane write and count logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        for (int i = 0; i < NO; i++) begin
            data_d[i] = data_q[i];
        end

        case (state_q)
            FILL: begin
                if (din_hs_s) begin
                    // Starting a new word clears every higher lane so unused lanes emit as zero.
                    for (int i = 0; i < NO; i++) begin
                        if (CNT_W'(i) == cnt_q) begin
                            data_d[i] = elem_s;
                        end else if (cnt_q == '0) begin
                            data_d[i] = '0;
                        end else begin
                            data_d[i] = data_q[i];
                        end
                    end
                    if (elem_last_s || (cnt_q == CNT_W'(NO - 1))) begin
                        active_d = W_ACTIVE'(cnt_q) + W_ACTIVE'(1);
                        cnt_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (dout_hs_s && din_hs_s) begin
                    data_d[0] = elem_s;
                    for (int i = 1; i < NO; i++) begin
                        data_d[i] = '0;
                    end
                    if (elem_last_s) begin
                        active_d = W_ACTIVE'(1);
                        cnt_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        cnt_d    = CNT_W'(1);
                        state_d  = FILL;
                    end
                end else if (dout_hs_s) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            active_q <= '0;
            for (int i = 0; i < NO; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            for (int i = 0; i < NO; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end
endmodule

// File: tb/tb_width_expander.sv
// Directed bench for width_expander: a scoreboard queue holds expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_width_expander;
    localparam int W_DATA   = 16;
    localparam int NO       = 4;
    localparam int W_ACTIVE = 3;
    localparam int WI       = W_DATA + 1;
    localparam int WO       = W_ACTIVE + NO * W_DATA;

    logic clk;
    logic rst;

    width_expander_if #(.W(WI)) din_if ();
    width_expander_if #(.W(WO)) dout_if ();

    width_expander #(.W_DATA(W_DATA), .NO(NO), .W_ACTIVE(W_ACTIVE)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din_if),
        .dout (dout_if)
    );

    int checks = 0;
    int errors = 0;
    logic [WO-1:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WO-1:0] act, input logic [WO-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare every accepted output word.
    always @(negedge clk) begin
        if (!rst && dout_if.valid === 1'b1 && dout_if.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h required=none", dout_if.data);
            end else begin
                check("word", dout_if.data, exp_q.pop_front());
            end
        end
    end

    function automatic logic [WO-1:0] mkw(input logic [2:0] act, input logic [15:0] d3,
                                          input logic [15:0] d2, input logic [15:0] d1,
                                          input logic [15:0] d0);
        return {act, d3, d2, d1, d0};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the element is accepted.
    task automatic send(input logic last, input logic [15:0] e, input logic chk_lat);
        logic hs;
        int   n;
        hs = 1'b0;
        n  = 0;
        din_if.valid = 1'b1;
        din_if.data  = {last, e};
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = din_if.ready;
            @(posedge clk);
            #1;
            n++;
        end
        din_if.valid = 1'b0;
        if (!hs) check("send_timeout", WO'(0), WO'(1));
        if (chk_lat) check("latency_valid", WO'(dout_if.valid), WO'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", WO'(exp_q.size()), WO'(0));
    endtask

    initial begin
        rst           = 1'b1;
        din_if.valid  = 1'b0;
        din_if.data   = '0;
        dout_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", WO'(dout_if.valid), WO'(0));
        check("reset_data", dout_if.data, WO'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", WO'(din_if.ready), WO'(1));

        // 1: full packet
        exp_q.push_back(mkw(3'd4, 16'h4444, 16'h3333, 16'h2222, 16'h1111));
        send(1'b0, 16'h1111, 1'b0);
        send(1'b0, 16'h2222, 1'b0);
        send(1'b0, 16'h3333, 1'b0);
        send(1'b1, 16'h4444, 1'b1);
        drain();

        // 2: short packet after a full one
        exp_q.push_back(mkw(3'd2, 16'h0000, 16'h0000, 16'hBBBB, 16'hAAAA));
        send(1'b0, 16'hAAAA, 1'b0);
        send(1'b1, 16'hBBBB, 1'b1);
        drain();

        // 3: oversize packet splits at NO
        exp_q.push_back(mkw(3'd4, 16'h0004, 16'h0003, 16'h0002, 16'h0001));
        exp_q.push_back(mkw(3'd2, 16'h0000, 16'h0000, 16'h0006, 16'h0005));
        for (int i = 1; i <= 6; i++) begin
            send((i == 6), 16'(i), (i == 4 || i == 6));
        end
        drain();

        // 4: backpressure with next element waiting
        dout_if.ready = 1'b0;
        send(1'b1, 16'h00A1, 1'b1);
        exp_q.push_back(mkw(3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h00A1));
        din_if.valid = 1'b1;
        din_if.data  = {1'b1, 16'h7777};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", WO'(dout_if.valid), WO'(1));
            check("bp_data", dout_if.data, mkw(3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h00A1));
            check("bp_din_ready", WO'(din_if.ready), WO'(0));
            @(posedge clk);
            #1;
        end
        dout_if.ready = 1'b1;
        exp_q.push_back(mkw(3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h7777));
        @(negedge clk);
        check("bp_release_ready", WO'(din_if.ready), WO'(1));
        @(posedge clk);
        #1;
        din_if.valid = 1'b0;
        check("bp_new_word_valid", WO'(dout_if.valid), WO'(1));
        drain();

        // 5: back-to-back single-element packets
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mkw(3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0C01 + 16'(i)));
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 16'h0C01 + 16'(i), 1'b1);
        end
        drain();

        // 6: reset mid-word discards the partial word
        send(1'b0, 16'h0101, 1'b0);
        send(1'b0, 16'h0202, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_valid", WO'(dout_if.valid), WO'(0));
        check("rst_mid_data", dout_if.data, WO'(0));
        exp_q.push_back(mkw(3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h5555));
        send(1'b1, 16'h5555, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", WO'(exp_q.size()), WO'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
